// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator and pixel pipeline. A clock-enable divider
// produces one pix_ce per pixel. Horizontal and vertical counters generate the
// framebuffer fetch coordinates. Sync and blank are delayed so that they line
// up with the colour that comes back from the framebuffer. Colour is forced to
// zero outside the active area. Double-buffer swaps are only accepted on entry
// to vertical front porch.
//
// Ports
//   CLOCK_50            in   system clock
//   resetn              in   asynchronous, active-low reset
//   pix_ce              out  one-CLOCK_50 pulse per pixel
//   VGA_CLK             out  registered pixel clock to the DAC
//   x / y               out  fetch coordinates (counters >> SCALE_SHIFT)
//   fetch_en            out  counters lie inside the active area
//   R_in / G_in / B_in  in   framebuffer colour, PIPE_LAT pixels after x/y
//   VGA_R / VGA_G / VGA_B  out  registered colour, zero when blanked
//   VGA_HS / VGA_VS     out  sync pulses, polarity set by HS_POL / VS_POL
//   VGA_BLANK           out  high while the delayed pixel is visible
//   VGA_SYNC            out  tied high
//   frame_start         out  pulse on the pix_ce at hcount=0, vcount=0
//   swap_req            in   level request for a buffer swap
//   swap_ack            out  one-pixel pulse when a swap is taken
//   buf_sel             out  display buffer index
//
// Vertical FSM
//   state      | meaning
//   ST_V_ACT   | visible lines 0..V_ACTIVE-1
//   ST_V_FRONT | vertical front porch
//   ST_V_SYNC  | vertical sync pulse
//   ST_V_BACK  | vertical back porch
// ----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int CLK_DIV     = 2,
  parameter int SCALE_SHIFT = 1,
  parameter int PIPE_LAT    = 1,
  parameter int COLOR_W     = 10,
  parameter int X_W         = 9,
  parameter int Y_W         = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  output logic               pix_ce,
  output logic               VGA_CLK,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic               fetch_en,
  input  logic [COLOR_W-1:0] R_in,
  input  logic [COLOR_W-1:0] G_in,
  input  logic [COLOR_W-1:0] B_in,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_HS,
  output logic               VGA_VS,
  output logic               VGA_BLANK,
  output logic               VGA_SYNC,
  output logic               frame_start,
  input  logic               swap_req,
  output logic               swap_ack,
  output logic               buf_sel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VACT_LAST  = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VFP_LAST   = 12'(V_ACTIVE + V_FP - 1);
  localparam logic [11:0] VSYNC_LAST = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    ST_V_ACT,
    ST_V_FRONT,
    ST_V_SYNC,
    ST_V_BACK
  } vstate_t;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               vga_clk_q;
  logic [11:0]        hcount_q, hcount_d;
  logic [11:0]        vcount_q, vcount_d;
  logic               h_wrap;
  vstate_t            vstate_q;
  logic               swap_ack_q;
  logic               buf_sel_q;
  logic               hs_raw, vs_raw, blank_raw;
  logic [PIPE_LAT:0]  hs_pipe_q, hs_pipe_d;
  logic [PIPE_LAT:0]  vs_pipe_q, vs_pipe_d;
  logic [PIPE_LAT:0]  blank_pipe_q, blank_pipe_d;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // ------------------------------------------------------------------------
  // Pixel divider and counters
  // ------------------------------------------------------------------------
  assign pix_ce = (div_q == DIV_LAST);
  assign h_wrap = (hcount_q == H_LAST);

  always_comb begin
    div_d    = pix_ce ? '0 : div_q + DIV_W'(1);
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_ce) begin
      if (h_wrap) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 12'd1;
      end else begin
        hcount_d = hcount_q + 12'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      div_q     <= '0;
      vga_clk_q <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
    end else begin
      div_q     <= div_d;
      vga_clk_q <= (div_q >= DIV_HALF);
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
    end
  end

  // ------------------------------------------------------------------------
  // Vertical FSM and swap arbitration. The swap decision is made on the same
  // pix_ce that leaves the last visible line, so the new buffer is selected
  // for the whole of vertical blank.
  // ------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      vstate_q   <= ST_V_ACT;
      swap_ack_q <= 1'b0;
      buf_sel_q  <= 1'b0;
    end else if (pix_ce) begin
      swap_ack_q <= 1'b0;
      if (h_wrap) begin
        case (vstate_q)
          ST_V_ACT: begin
            if (vcount_q == VACT_LAST) begin
              vstate_q <= ST_V_FRONT;
              if (swap_req) begin
                swap_ack_q <= 1'b1;
                buf_sel_q  <= ~buf_sel_q;
              end
            end
          end
          ST_V_FRONT: if (vcount_q == VFP_LAST)   vstate_q <= ST_V_SYNC;
          ST_V_SYNC:  if (vcount_q == VSYNC_LAST) vstate_q <= ST_V_BACK;
          ST_V_BACK:  if (vcount_q == V_LAST)     vstate_q <= ST_V_ACT;
          default:                                vstate_q <= ST_V_ACT;
        endcase
      end
    end
  end

  // ------------------------------------------------------------------------
  // Raw syncs / blank and their alignment pipeline. Pipes hold active-high
  // values; polarity is applied at the pins so reset fills them inactive.
  // ------------------------------------------------------------------------
  assign hs_raw    = (hcount_q >= HS_START) && (hcount_q < HS_END);
  assign vs_raw    = (vstate_q == ST_V_SYNC);
  assign blank_raw = (hcount_q < H_ACT_END) && (vstate_q == ST_V_ACT);

  always_comb begin
    hs_pipe_d       = hs_pipe_q;
    vs_pipe_d       = vs_pipe_q;
    blank_pipe_d    = blank_pipe_q;
    hs_pipe_d[0]    = hs_raw;
    vs_pipe_d[0]    = vs_raw;
    blank_pipe_d[0] = blank_raw;
    for (int i = 1; i <= PIPE_LAT; i++) begin
      hs_pipe_d[i]    = hs_pipe_q[i-1];
      vs_pipe_d[i]    = vs_pipe_q[i-1];
      blank_pipe_d[i] = blank_pipe_q[i-1];
    end
  end

  // blank_pipe_d[PIPE_LAT] is the blank of the pixel whose colour is at the
  // inputs right now; gating with it keeps colour coincident with VGA_BLANK.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      hs_pipe_q    <= '0;
      vs_pipe_q    <= '0;
      blank_pipe_q <= '0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
    end else if (pix_ce) begin
      hs_pipe_q    <= hs_pipe_d;
      vs_pipe_q    <= vs_pipe_d;
      blank_pipe_q <= blank_pipe_d;
      r_q          <= blank_pipe_d[PIPE_LAT] ? R_in : '0;
      g_q          <= blank_pipe_d[PIPE_LAT] ? G_in : '0;
      b_q          <= blank_pipe_d[PIPE_LAT] ? B_in : '0;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  assign VGA_CLK     = vga_clk_q;
  assign x           = X_W'(hcount_q >> SCALE_SHIFT);
  assign y           = Y_W'(vcount_q >> SCALE_SHIFT);
  assign fetch_en    = (hcount_q < H_ACT_END) && (vcount_q < V_ACT_END);
  // Gated by pix_ce so it is a single-cycle pulse and stays low in reset.
  assign frame_start = pix_ce && (hcount_q == '0) && (vcount_q == '0);
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_pipe_q[PIPE_LAT] ? HS_POL : ~HS_POL;
  assign VGA_VS      = vs_pipe_q[PIPE_LAT] ? VS_POL : ~VS_POL;
  assign VGA_BLANK   = blank_pipe_q[PIPE_LAT];
  assign VGA_SYNC    = 1'b1;
  assign swap_ack    = swap_ack_q;
  assign buf_sel     = buf_sel_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 4;
  localparam int VA = 8,  VFP = 2, VSY = 2, VBP = 3;
  localparam bit HS_POL = 1'b1;
  localparam bit VS_POL = 1'b0;
  localparam int D = 3;
  localparam int SS = 2;
  localparam int PL = 3;
  localparam int CW = 10;
  localparam int X_W = 3;
  localparam int Y_W = 2;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int L = PL + 1;

  logic          CLOCK_50;
  logic          resetn;
  logic          pix_ce, VGA_CLK, fetch_en, frame_start, swap_ack, buf_sel;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [CW-1:0] R_in, G_in, B_in, VGA_R, VGA_G, VGA_B;
  logic          VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
  logic          swap_req;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .CLK_DIV(D), .SCALE_SHIFT(SS),
    .PIPE_LAT(PL), .COLOR_W(CW), .X_W(X_W), .Y_W(Y_W)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .pix_ce(pix_ce), .VGA_CLK(VGA_CLK),
    .x(x), .y(y), .fetch_en(fetch_en), .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
    .frame_start(frame_start), .swap_req(swap_req), .swap_ack(swap_ack),
    .buf_sel(buf_sel)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int x; int y; bit fe; bit fs; bit hs; bit vs; bit bl;
    int r; int g; int b; bit ack; bit bsel;
  } exp_t;

  exp_t q[$];
  int   rin_r [0:4095];
  int   rin_g [0:4095];
  int   rin_b [0:4095];
  bit   sreq  [0:4095];
  bit   bsel_m;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  int   mon_t  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected outputs during pixel period k after reset release, derived from
  // the raster position of pixel k and of the pixel L periods earlier.
  function automatic exp_t model(int k);
    exp_t e;
    int h, v, c, hc, vc;
    bit hsa, vsa, bl;
    h = k % HT;
    v = (k / HT) % VT;
    e.x  = (h >> SS) & ((1 << X_W) - 1);
    e.y  = (v >> SS) & ((1 << Y_W) - 1);
    e.fe = (h < HA) && (v < VA);
    e.fs = (h == 0) && (v == 0);
    c = k - L;
    hsa = 0; vsa = 0; bl = 0;
    if (c >= 0) begin
      hc  = c % HT;
      vc  = (c / HT) % VT;
      hsa = (hc >= HA + HFP) && (hc < HA + HFP + HSY);
      vsa = (vc >= VA + VFP) && (vc < VA + VFP + VSY);
      bl  = (hc < HA) && (vc < VA);
    end
    e.hs = hsa ? HS_POL : !HS_POL;
    e.vs = vsa ? VS_POL : !VS_POL;
    e.bl = bl;
    e.r  = bl ? rin_r[k-1] : 0;
    e.g  = bl ? rin_g[k-1] : 0;
    e.b  = bl ? rin_b[k-1] : 0;
    e.ack = (k >= 1) && (h == 0) && (v == VA) && sreq[k-1];
    e.bsel = 1'b0;
    return e;
  endfunction

  // Swap request policy per frame: held, held, dropped exactly on the last
  // pixel before front porch, never, held, then random.
  function automatic bit swap_policy(int k);
    int f, h, v;
    f = k / FRAME;
    h = k % HT;
    v = (k / HT) % VT;
    case (f)
      0, 1, 4: return (v >= 1);
      2:       return !((v == VA - 1) && (h == HT - 1));
      3:       return 1'b0;
      default: return ($urandom_range(0, 1) == 1);
    endcase
  endfunction

  task automatic run_pixels(input int npix);
    exp_t e;
    for (int k = 0; k < npix; k++) begin
      rin_r[k] = $urandom_range(0, (1 << CW) - 1);
      rin_g[k] = $urandom_range(0, (1 << CW) - 1);
      rin_b[k] = $urandom_range(0, (1 << CW) - 1);
      sreq[k]  = swap_policy(k);
      R_in     = CW'(rin_r[k]);
      G_in     = CW'(rin_g[k]);
      B_in     = CW'(rin_b[k]);
      swap_req = sreq[k];
      e = model(k);
      if (e.ack) bsel_m = ~bsel_m;
      e.bsel = bsel_m;
      q.push_back(e);
      repeat (D) @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hs"},    VGA_HS,      !HS_POL);
    chk({tag, "_vs"},    VGA_VS,      !VS_POL);
    chk({tag, "_blank"}, VGA_BLANK,   0);
    chk({tag, "_r"},     VGA_R,       0);
    chk({tag, "_g"},     VGA_G,       0);
    chk({tag, "_b"},     VGA_B,       0);
    chk({tag, "_vgaclk"}, VGA_CLK,    0);
    chk({tag, "_ack"},   swap_ack,    0);
    chk({tag, "_bsel"},  buf_sel,     0);
    chk({tag, "_fs"},    frame_start, 0);
    chk({tag, "_pixce"}, pix_ce,      0);
  endtask

  // Monitor: per-cycle divider checks, and one scoreboard pop per pix_ce.
  always @(negedge CLOCK_50) begin
    if (mon_on) begin
      exp_t e;
      chk("pix_ce", pix_ce, (mon_t % D) == D - 1);
      chk("vga_clk", VGA_CLK, (mon_t == 0) ? 0 : (((mon_t - 1) % D) >= D / 2));
      if (pix_ce) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty got pix_ce expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("x",           x,           e.x);
          chk("y",           y,           e.y);
          chk("fetch_en",    fetch_en,    e.fe);
          chk("frame_start", frame_start, e.fs);
          chk("hs",          VGA_HS,      e.hs);
          chk("vs",          VGA_VS,      e.vs);
          chk("blank",       VGA_BLANK,   e.bl);
          chk("r",           VGA_R,       e.r);
          chk("g",           VGA_G,       e.g);
          chk("b",           VGA_B,       e.b);
          chk("swap_ack",    swap_ack,    e.ack);
          chk("buf_sel",     buf_sel,     e.bsel);
          chk("vga_sync",    VGA_SYNC,    1);
        end
      end
      mon_t++;
    end
  end

  initial begin
    resetn   = 1'b0;
    R_in     = '0;
    G_in     = '0;
    B_in     = '0;
    swap_req = 1'b0;
    bsel_m   = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("por");
    resetn = 1'b1;
    mon_t  = 0;
    mon_on = 1'b1;
    // Five frames plus part of a sixth, stopping mid-frame at line 6.
    run_pixels(5 * FRAME + 6 * HT + 7);
    chk("queue_drained_1", q.size(), 0);
    // Asynchronous reset in the middle of a pixel period.
    mon_on = 1'b0;
    q.delete();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("midreset_hold");
    resetn = 1'b1;
    bsel_m = 1'b0;
    mon_t  = 0;
    mon_on = 1'b1;
    run_pixels(2 * FRAME + 10);
    mon_on = 1'b0;
    chk("queue_drained_2", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
